// File: rtl/boot_loader.sv
// Boot loader: streams a program into instruction memory one word at a time,
// then holds the core in reset for a short settling window before releasing it.
module boot_loader #(
  parameter int INSTR_DEPTH    = 128,
  parameter int RELEASE_CYCLES = 4,
  parameter int GNT_TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start_ip,
  input  logic        load_valid_ip,
  input  logic [31:0] load_word_ip,
  input  logic        load_last_ip,
  output logic        load_ready_op,
  output logic        imem_we_op,
  output logic [31:0] imem_addr_op,
  output logic [31:0] imem_wdata_op,
  input  logic        imem_gnt_ip,
  output logic        core_reset_op,
  output logic        core_mem_en_op,
  output logic        load_done_op,
  output logic        load_err_op,
  output logic [7:0]  word_count_op
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int GW = $clog2(GNT_TIMEOUT) + 1;
  localparam int RW = $clog2(RELEASE_CYCLES) + 1;
  localparam logic [7:0]    DEPTH_CNT = 8'(INSTR_DEPTH);
  localparam logic [GW-1:0] GNT_LAST  = GW'(GNT_TIMEOUT - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [7:0]    count_reg, count_next;
  logic [31:0]   word_reg, word_next;
  logic          last_reg, last_next;
  logic [GW-1:0] wait_reg, wait_next;
  logic [RW-1:0] rel_reg, rel_next;
  logic          err_reg, err_next;
  logic          core_reset_reg, core_mem_en_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      word_reg        <= '0;
      last_reg        <= 1'b0;
      wait_reg        <= '0;
      rel_reg         <= '0;
      err_reg         <= 1'b0;
      core_reset_reg  <= 1'b0;
      core_mem_en_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      word_reg        <= word_next;
      last_reg        <= last_next;
      wait_reg        <= wait_next;
      rel_reg         <= rel_next;
      err_reg         <= err_next;
      // Core controls are decoded from the next state so they flip on the
      // same edge as the state and come straight out of flops.
      core_reset_reg  <= (state_next == RUN);
      core_mem_en_reg <= (state_next == RELEASE) || (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    word_next  = word_reg;
    last_next  = last_reg;
    wait_next  = '0;
    rel_next   = '0;
    err_next   = err_reg;

    case (state_reg)
      IDLE, RUN, ERROR: begin
        if (load_start_ip) begin
          state_next = LOAD;
          count_next = '0;
          err_next   = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid_ip) begin
          word_next  = load_word_ip;
          last_next  = load_last_ip;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (imem_gnt_ip) begin
          count_next = count_reg + 8'd1;
          if (last_reg)
            state_next = RELEASE;
          else if (count_reg + 8'd1 == DEPTH_CNT)
            state_next = ERROR;
          else
            state_next = LOAD;
        end else if (wait_reg == GNT_LAST) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_reg + GW'(1);
        end
      end
      RELEASE: begin
        if (rel_reg == REL_LAST)
          state_next = RUN;
        else
          rel_next = rel_reg + RW'(1);
      end
      default: state_next = IDLE;
    endcase

    if (state_next == ERROR)
      err_next = 1'b1;
  end

  assign load_ready_op  = (state_reg == LOAD);
  assign imem_we_op     = (state_reg == WRITE);
  assign imem_addr_op   = {22'd0, count_reg, 2'b00};
  assign imem_wdata_op  = word_reg;
  assign core_reset_op  = core_reset_reg;
  assign core_mem_en_op = core_mem_en_reg;
  assign load_done_op   = (state_reg == RUN);
  assign load_err_op    = err_reg;
  assign word_count_op  = count_reg;

endmodule
